// File: rtl/lane_tx_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module      : lane_tx_scheduler_if
// Description : Bundle of the lane-side and serializer-side signals of the
//               four-lane round-robin TX scheduler.
//               master : upstream lane sources + serializer/link control
//               slave  : the scheduler itself
// Ports       : data_Np/valid_Np -> lane bytes in, ready_Np <- lane empty,
//               active/ser_ready -> link up / slot strobe,
//               data_out/valid_out/lane_id/idle_out/tx_count <- slot output
// Revision    : 1.0 - initial release
// ============================================================================
interface lane_tx_scheduler_if;
  logic [7:0] data_0p, data_1p, data_2p, data_3p;
  logic       valid_0p, valid_1p, valid_2p, valid_3p;
  logic       ready_0p, ready_1p, ready_2p, ready_3p;
  logic       active;
  logic       ser_ready;
  logic [7:0] data_out;
  logic       valid_out;
  logic [1:0] lane_id;
  logic       idle_out;
  logic [7:0] tx_count;

  modport master (
    output data_0p, data_1p, data_2p, data_3p,
    output valid_0p, valid_1p, valid_2p, valid_3p,
    output active, ser_ready,
    input  ready_0p, ready_1p, ready_2p, ready_3p,
    input  data_out, valid_out, lane_id, idle_out, tx_count
  );

  modport slave (
    input  data_0p, data_1p, data_2p, data_3p,
    input  valid_0p, valid_1p, valid_2p, valid_3p,
    input  active, ser_ready,
    output ready_0p, ready_1p, ready_2p, ready_3p,
    output data_out, valid_out, lane_id, idle_out, tx_count
  );
endinterface
`default_nettype wire

// File: rtl/lane_tx_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : lane_tx_scheduler
// Description : Merges four parallel byte lanes into one byte stream for the
//               PPTX serializer. One holding register per lane, round-robin
//               grant per serializer slot, IDLE_CODE on empty/link-down slots
//               and a forced IDLE after IDLE_PERIOD consecutive data bytes.
// Ports       : clk_4f - clock (posedge)
//               reset  - asynchronous active-low reset
//               bus    - lane_tx_scheduler_if.slave (lanes, link, output slot)
// Revision    : 1.0 - initial release
// ============================================================================
module lane_tx_scheduler #(
  parameter logic [7:0]  IDLE_CODE   = 8'hBC,
  parameter int unsigned IDLE_PERIOD = 16
) (
  input  logic                  clk_4f,
  input  logic                  reset,
  lane_tx_scheduler_if.slave    bus
);

  localparam logic [7:0] c_idle_period = IDLE_PERIOD[7:0];

  logic [7:0] w_lane_data [4];
  logic [3:0] w_lane_valid;

  logic [7:0] r_hold [4];
  logic [3:0] r_full;
  logic [1:0] r_ptr;
  logic [7:0] r_run;
  logic [7:0] r_data_out;
  logic       r_valid_out;
  logic [1:0] r_lane_id;
  logic       r_idle_out;
  logic [7:0] r_tx_count;

  logic [1:0] w_sel;
  logic [1:0] w_idx;
  logic       w_grant;

  assign w_lane_data[0] = bus.data_0p;
  assign w_lane_data[1] = bus.data_1p;
  assign w_lane_data[2] = bus.data_2p;
  assign w_lane_data[3] = bus.data_3p;
  assign w_lane_valid   = {bus.valid_3p, bus.valid_2p, bus.valid_1p, bus.valid_0p};

  // Ready comes straight from the full flags so no grant path reaches the lanes.
  assign bus.ready_0p  = ~r_full[0];
  assign bus.ready_1p  = ~r_full[1];
  assign bus.ready_2p  = ~r_full[2];
  assign bus.ready_3p  = ~r_full[3];

  assign bus.data_out  = r_data_out;
  assign bus.valid_out = r_valid_out;
  assign bus.lane_id   = r_lane_id;
  assign bus.idle_out  = r_idle_out;
  assign bus.tx_count  = r_tx_count;

  // Scan from the farthest offset back to ptr so the nearest full lane wins.
  always_comb begin
    w_sel = r_ptr;
    w_idx = r_ptr;
    for (int k = 3; k >= 0; k--) begin
      w_idx = r_ptr + 2'(k);
      if (r_full[w_idx]) w_sel = w_idx;
    end
  end

  assign w_grant = bus.active && (|r_full) && (r_run < c_idle_period);

  always_ff @(posedge clk_4f or negedge reset) begin
    if (!reset) begin
      for (int n = 0; n < 4; n++) r_hold[n] <= 8'd0;
      r_full      <= 4'd0;
      r_ptr       <= 2'd0;
      r_run       <= 8'd0;
      r_data_out  <= IDLE_CODE;
      r_valid_out <= 1'b0;
      r_lane_id   <= 2'd0;
      r_idle_out  <= 1'b1;
      r_tx_count  <= 8'd0;
    end else begin
      for (int n = 0; n < 4; n++) begin
        if (w_lane_valid[n] && !r_full[n]) begin
          r_hold[n] <= w_lane_data[n];
          r_full[n] <= 1'b1;
        end
      end

      if (bus.ser_ready) begin
        if (w_grant) begin
          // A granted lane is full, so the capture loop above never touched it.
          r_data_out    <= r_hold[w_sel];
          r_valid_out   <= 1'b1;
          r_idle_out    <= 1'b0;
          r_lane_id     <= w_sel;
          r_full[w_sel] <= 1'b0;
          r_ptr         <= w_sel + 2'd1;
          r_run         <= r_run + 8'd1;
          r_tx_count    <= r_tx_count + 8'd1;
        end else begin
          r_data_out  <= IDLE_CODE;
          r_valid_out <= 1'b0;
          r_idle_out  <= 1'b1;
          r_run       <= 8'd0;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_lane_tx_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_lane_tx_scheduler
// Description : Self-checking bench for lane_tx_scheduler (IDLE_PERIOD = 4).
//               Expected slot outputs are queued when stimulus is driven and
//               popped when the slot has been produced.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lane_tx_scheduler;

  logic clk_4f = 1'b0;
  logic reset  = 1'b0;

  lane_tx_scheduler_if bus();

  lane_tx_scheduler #(
    .IDLE_CODE   (8'hBC),
    .IDLE_PERIOD (4)
  ) dut (
    .clk_4f (clk_4f),
    .reset  (reset),
    .bus    (bus.slave)
  );

  always #5 clk_4f = ~clk_4f;

  typedef struct packed {
    logic [7:0] d;
    logic       v;
    logic [1:0] l;
    logic       i;
  } slot_t;

  int         n_checks = 0;
  int         n_errors = 0;
  slot_t      sb[$];
  logic [7:0] q2[$];
  logic [3:0] refill  = 4'd0;
  logic [3:0] oneshot = 4'd0;
  logic [7:0] os_data [4];
  logic [7:0] cnt [4];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] ready_vec();
    return {bus.ready_3p, bus.ready_2p, bus.ready_1p, bus.ready_0p};
  endfunction

  task automatic drive_lanes();
    bus.valid_0p = refill[0] | oneshot[0];
    bus.valid_1p = refill[1] | oneshot[1];
    bus.valid_2p = refill[2] | oneshot[2];
    bus.valid_3p = refill[3] | oneshot[3];
    bus.data_0p  = oneshot[0] ? os_data[0] : {2'd0, cnt[0][5:0]};
    bus.data_1p  = oneshot[1] ? os_data[1] : {2'd1, cnt[1][5:0]};
    bus.data_2p  = oneshot[2] ? os_data[2] : {2'd2, cnt[2][5:0]};
    bus.data_3p  = oneshot[3] ? os_data[3] : {2'd3, cnt[3][5:0]};
  endtask

  // One clock; acc reports which lanes handed over a byte on this edge.
  task automatic tick(output logic [3:0] acc);
    acc = (refill | oneshot) & ready_vec();
    @(posedge clk_4f);
    #1;
    for (int n = 0; n < 4; n++) begin
      if (acc[n]) begin
        if (oneshot[n]) oneshot[n] = 1'b0;
        else            cnt[n]     = cnt[n] + 8'd1;
      end
    end
    drive_lanes();
  endtask

  task automatic do_reset();
    logic [3:0] a;
    refill  = 4'd0;
    oneshot = 4'd0;
    reset   = 1'b0;
    drive_lanes();
    tick(a);
    reset = 1'b1;
    for (int n = 0; n < 4; n++) cnt[n] = 8'd0;
    drive_lanes();
  endtask

  task automatic push_slot(input logic [7:0] d, input logic v, input logic [1:0] l, input logic i);
    slot_t e;
    e = {d, v, l, i};
    sb.push_back(e);
  endtask

  task automatic pop_check(input string tag);
    slot_t e;
    check({tag, "_sb"}, 32'(sb.size() != 0), 32'd1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check(tag, {20'd0, bus.data_out, bus.valid_out, bus.lane_id, bus.idle_out}, {20'd0, e});
    end
  endtask

  // Steady-state pattern with every lane kept full: four data slots in
  // lane order 0..3, then one forced IDLE; lane n's k-th byte is {n,k}.
  function automatic slot_t t5_exp(input int s);
    slot_t e;
    int    idx;
    idx = s - s / 5;
    if (s % 5 == 4) e = {8'hBC, 1'b0, 2'((idx - 1) % 4), 1'b1};
    else            e = {2'(idx % 4), 6'(idx / 4), 1'b1, 2'(idx % 4), 1'b0};
    return e;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] a;
    logic [7:0] pre2;
    int         wait0;
    logic       loaded0;
    logic       seen77;

    for (int n = 0; n < 4; n++) begin
      cnt[n]     = 8'd0;
      os_data[n] = 8'd0;
    end

    // T1: reset held with random inputs
    for (int r = 0; r < 2; r++) begin
      bus.data_0p  = 8'($urandom); bus.data_1p = 8'($urandom);
      bus.data_2p  = 8'($urandom); bus.data_3p = 8'($urandom);
      bus.valid_0p = 1'($urandom); bus.valid_1p = 1'($urandom);
      bus.valid_2p = 1'($urandom); bus.valid_3p = 1'($urandom);
      bus.active   = 1'($urandom); bus.ser_ready = 1'($urandom);
      @(posedge clk_4f);
      #1;
      check("t1_data",  32'(bus.data_out),  32'hBC);
      check("t1_idle",  32'(bus.idle_out),  32'd1);
      check("t1_valid", 32'(bus.valid_out), 32'd0);
      check("t1_ready", 32'(ready_vec()),   32'hF);
      check("t1_tx",    32'(bus.tx_count),  32'd0);
    end
    do_reset();

    // T2: link gating
    bus.active = 1'b0; bus.ser_ready = 1'b1;
    oneshot[0] = 1'b1; os_data[0] = 8'hA5;
    drive_lanes();
    tick(a);
    check("t2_ready0", 32'(bus.ready_0p), 32'd0);
    check("t2_gated",  32'(bus.data_out), 32'hBC);
    tick(a);
    check("t2_still_gated", 32'(bus.data_out), 32'hBC);
    bus.active = 1'b1;
    push_slot(8'hA5, 1'b1, 2'd0, 1'b0); tick(a); pop_check("t2_send");
    push_slot(8'hBC, 1'b0, 2'd0, 1'b1); tick(a); pop_check("t2_idle");
    check("t2_tx",     32'(bus.tx_count), 32'd1);
    check("t2_ready0b", 32'(bus.ready_0p), 32'd1);

    // T3: round-robin over four loaded lanes
    do_reset();
    bus.active = 1'b0; bus.ser_ready = 1'b1;
    oneshot = 4'hF;
    os_data[0] = 8'h10; os_data[1] = 8'h21; os_data[2] = 8'h32; os_data[3] = 8'h43;
    drive_lanes();
    tick(a);
    bus.active = 1'b1;
    push_slot(8'h10, 1'b1, 2'd0, 1'b0);
    push_slot(8'h21, 1'b1, 2'd1, 1'b0);
    push_slot(8'h32, 1'b1, 2'd2, 1'b0);
    push_slot(8'h43, 1'b1, 2'd3, 1'b0);
    push_slot(8'hBC, 1'b0, 2'd3, 1'b1);
    for (int s = 0; s < 5; s++) begin
      tick(a);
      pop_check("t3_slot");
    end
    check("t3_tx", 32'(bus.tx_count), 32'd4);

    // T6: reset after the second byte of the T3 sequence
    do_reset();
    bus.active = 1'b0;
    oneshot = 4'hF;
    drive_lanes();
    tick(a);
    bus.active = 1'b1;
    push_slot(8'h10, 1'b1, 2'd0, 1'b0); tick(a); pop_check("t6_b0");
    push_slot(8'h21, 1'b1, 2'd1, 1'b0); tick(a); pop_check("t6_b1");
    reset = 1'b0;
    #1;
    check("t6_async_data",  32'(bus.data_out),  32'hBC);
    check("t6_async_valid", 32'(bus.valid_out), 32'd0);
    check("t6_async_idle",  32'(bus.idle_out),  32'd1);
    check("t6_async_lane",  32'(bus.lane_id),   32'd0);
    check("t6_async_tx",    32'(bus.tx_count),  32'd0);
    check("t6_async_ready", 32'(ready_vec()),   32'hF);
    do_reset();
    bus.active = 1'b1;
    oneshot[3] = 1'b1; os_data[3] = 8'h55;
    drive_lanes();
    push_slot(8'hBC, 1'b0, 2'd0, 1'b1); tick(a); pop_check("t6_load");
    push_slot(8'h55, 1'b1, 2'd3, 1'b0); tick(a); pop_check("t6_new");
    push_slot(8'hBC, 1'b0, 2'd3, 1'b1); tick(a); pop_check("t6_after");

    // T4: fairness with lane 2 refilled every cycle
    do_reset();
    bus.active = 1'b1; bus.ser_ready = 1'b1;
    refill  = 4'b0100;
    wait0   = 0;
    loaded0 = 1'b0;
    seen77  = 1'b0;
    drive_lanes();
    for (int c = 0; c < 40; c++) begin
      if (c == 9) begin oneshot[0] = 1'b1; os_data[0] = 8'h77; end
      if (c == 30) refill = 4'd0;
      drive_lanes();
      pre2 = {2'd2, cnt[2][5:0]};
      tick(a);
      if (a[2]) q2.push_back(pre2);
      if (a[0]) loaded0 = 1'b1;
      if (bus.valid_out) begin
        if (loaded0 && !seen77) wait0++;
        if (bus.lane_id == 2'd2) begin
          check("t4_lane2_sb", 32'(q2.size() != 0), 32'd1);
          if (q2.size() != 0) check("t4_lane2", 32'(bus.data_out), 32'(q2.pop_front()));
        end else if (bus.lane_id == 2'd0) begin
          check("t4_lane0", 32'(bus.data_out), 32'h77);
          check("t4_fair",  32'(wait0 <= 4),   32'd1);
          seen77 = 1'b1;
        end else begin
          check("t4_lane_id", 32'(bus.lane_id), 32'd2);
        end
      end
    end
    check("t4_drained", 32'(q2.size()), 32'd0);
    check("t4_seen77",  32'(seen77),    32'd1);

    // T5: forced IDLE with all lanes kept full, plus a stalled slot
    do_reset();
    bus.active = 1'b1; bus.ser_ready = 1'b0;
    refill = 4'hF;
    drive_lanes();
    tick(a);
    bus.ser_ready = 1'b1;
    for (int s = 0; s < 15; s++) begin
      sb.push_back(t5_exp(s));
      tick(a);
      pop_check("t5_slot");
      if (s == 7) begin
        bus.ser_ready = 1'b0;
        sb.push_back(t5_exp(7));
        tick(a);
        pop_check("t5_hold");
        bus.ser_ready = 1'b1;
      end
    end
    refill = 4'd0;
    drive_lanes();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
